// File: rtl/pio_entrada_irq.sv
// Avalon-MM input port: synchronised, debounced pins with edge capture and a maskable level irq.
// Latency: pin to data register is SYNC_STAGES + DEBOUNCE_CYCLES (min 1) cycles; readdata one cycle after address.
// Backpressure: none; the slave is wait-state free and accepts a read or write every cycle.
module pio_entrada_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;
  assign sync  = sync_q[SYNC_STAGES-1];

  // Bits above WIDTH on the write bus carry no state.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  // Metastability chain: in_port enters stage 0, sync is the last stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    // Bypass: accept the synchronised level on every edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) deb <= '0;
      else          deb <= sync;
    end
  end else begin : g_debounce
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt_q [WIDTH];

    // Per-bit hold counter: a new level is accepted only after it persists; any return restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb <= '0;
        for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sync[i] == deb[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            deb[i]   <= sync[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end
      end
    end
  end

  // Edge qualifier chosen by EDGE_TYPE: 1 falling, 2 any, otherwise rising.
  always_comb begin
    if (EDGE_TYPE == 1)      edge_det = ~deb & prev;
    else if (EDGE_TYPE == 2) edge_det = deb ^ prev;
    else                     edge_det = deb & ~prev;
  end

  // Write-1-to-clear mask for edgecapture.
  always_comb begin
    clr_mask = '0;
    if (wr_en && address == 2'd3) clr_mask = writedata[WIDTH-1:0];
  end

  // Edge history, mask register and sticky capture; a new edge overrides a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      prev        <= deb;
      edgecapture <= (edgecapture & ~clr_mask) | edge_det;
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Register map decode, zero-extended to 32 bits; reserved word reads zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = deb;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  // Read data registered every edge, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_entrada_irq.sv
// Testbench for pio_entrada_irq: several parameterisations share one bus.
// Latency: reads are checked exactly one cycle after the address is driven.
// Backpressure: none; stimulus is fixed-cycle directed steps.
module tb_pio_entrada_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in0, in1, in2, in3;
  logic [4:0]  in4;
  logic [31:0] rd0, rd1, rd2, rd3, rd4;
  logic        irq0, irq1, irq2, irq3, irq4;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  pio_entrada_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
  pio_entrada_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));
  pio_entrada_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));
  pio_entrada_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in3), .readdata(rd3), .irq(irq3));
  pio_entrada_irq #(.WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in4), .readdata(rd4), .irq(irq4));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input int inst);
    case (inst)
      0:       return rd0;
      1:       return rd1;
      2:       return rd2;
      3:       return rd3;
      default: return rd4;
    endcase
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Expected value queued when the address is driven, compared when readdata appears.
  task automatic bus_read(input int inst, input logic [1:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    address = a;
    tick(1);
    check(tag_q.pop_front(), rd_of(inst), exp_q.pop_front());
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in0 = 8'hA5;
    in1 = '0;
    in2 = '0;
    in3 = '0;
    in4 = '0;

    // Reset held with pins driven
    tick(3);
    check("rst_readdata", rd0, 32'h0);
    check("rst_irq", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;
    tick(2);
    bus_read(0, 2'd0, 32'h0, "lat_early");
    bus_read(0, 2'd0, 32'h0000_00A5, "lat_data");
    bus_read(0, 2'd3, 32'h0000_00A5, "rst_release_edges");
    bus_write(2'd3, 32'hFF, 1'b1);
    bus_read(0, 2'd3, 32'h0, "w1c_all");

    // Rising edge on bit0 with mask set
    in0 = 8'hA4;
    tick(5);
    bus_write(2'd2, 32'h1, 1'b1);
    check("irq_idle", {31'b0, irq0}, 32'h0);
    in0 = 8'hA5;
    tick(3);
    check("irq_early", {31'b0, irq0}, 32'h0);
    tick(1);
    check("irq_edge", {31'b0, irq0}, 32'h1);
    bus_read(0, 2'd3, 32'h1, "ec_bit0");
    bus_write(2'd2, 32'h0, 1'b1);
    check("irq_masked", {31'b0, irq0}, 32'h0);
    bus_write(2'd2, 32'h1, 1'b1);
    check("irq_mask_on_captured", {31'b0, irq0}, 32'h1);
    bus_write(2'd3, 32'h1, 1'b1);
    check("irq_after_w1c", {31'b0, irq0}, 32'h0);
    bus_read(0, 2'd3, 32'h0, "ec_after_w1c");

    // Edge on bit5 in the same cycle as its clear
    in0 = 8'h85;
    tick(5);
    bus_read(0, 2'd3, 32'h0, "fall_ignored");
    in0 = 8'hA5;
    tick(3);
    bus_write(2'd3, 32'h20, 1'b1);
    bus_read(0, 2'd3, 32'h20, "edge_beats_clear");
    bus_write(2'd3, 32'h20, 1'b1);
    bus_read(0, 2'd3, 32'h0, "w1c_bit5");

    // Register map
    bus_write(2'd0, 32'hFFFF_FFFF, 1'b1);
    bus_write(2'd1, 32'hFFFF_FFFF, 1'b1);
    bus_read(0, 2'd0, 32'h0000_00A5, "data_ro");
    bus_read(0, 2'd1, 32'h0, "reserved");
    bus_read(0, 2'd2, 32'h1, "mask_kept");
    bus_read(0, 2'd3, 32'h0, "ec_kept");
    bus_write(2'd2, 32'hFF, 1'b0);
    bus_read(0, 2'd2, 32'h1, "cs0_ignored");

    // Debounce: 3-cycle glitch filtered, steady level accepted after 4 cycles in sync
    for (int k = 0; k < 8; k++) begin
      if (k == 0) in1[3] = 1'b1;
      if (k == 3) in1[3] = 1'b0;
      bus_read(1, 2'd0, 32'h0, "deb_glitch");
    end
    tick(4);
    bus_read(1, 2'd3, 32'h0, "deb_glitch_no_edge");
    in1[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      bus_read(1, 2'd0, (k >= 7) ? 32'h8 : 32'h0, "deb_hold");
    end
    bus_read(1, 2'd3, 32'h8, "deb_edge");
    bus_write(2'd3, 32'h8, 1'b1);
    tick(6);
    bus_read(1, 2'd3, 32'h0, "deb_edge_once");

    // Falling (u2) and any (u3) edge types on bit2
    in2[2] = 1'b1;
    in3[2] = 1'b1;
    tick(6);
    bus_read(2, 2'd3, 32'h0, "fall_on_rise");
    bus_read(3, 2'd3, 32'h4, "any_on_rise");
    bus_write(2'd3, 32'h4, 1'b1);
    bus_read(3, 2'd3, 32'h0, "any_cleared");
    in2[2] = 1'b0;
    in3[2] = 1'b0;
    tick(6);
    bus_read(2, 2'd3, 32'h4, "fall_on_fall");
    bus_read(3, 2'd3, 32'h4, "any_on_fall");
    bus_write(2'd3, 32'h4, 1'b1);
    tick(6);
    bus_read(2, 2'd3, 32'h0, "fall_once");

    // Narrow instance masks upper bits
    bus_write(2'd2, 32'hFFFF_FFFF, 1'b1);
    bus_read(4, 2'd2, 32'h0000_001F, "w5_mask");
    bus_read(0, 2'd2, 32'h0000_00FF, "w8_mask");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
